fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer_if.sv | 52 +++++
 rtl/fir_mac_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer_if
// Description : Bundle of the sequencer's sample, RAM/ROM address and MAC
//               control signals.
//               master modport : the sequencer (drives addresses and controls)
//               slave modport  : the sample source plus RAM/ROM/MAC datapath
// Signals     : sample_strobe  new input sample present (one-cycle pulse)
//               sample_we      sample RAM write enable
//               wr_addr        sample RAM write address (ring write pointer)
//               rd_addr        sample RAM read address
//               coeff_addr     coefficient ROM address
//               mac_reset      clear MAC accumulator and product register
//               mac_wren       MAC multiply/accumulate enable
//               mac_rden       MAC output latch enable
//               data_zero      force both multiplier operands to zero
//               out_strobe     MAC output valid (one-cycle pulse)
//               busy           computation in progress
//               overrun        sticky: trigger arrived while busy
// Revision    : 1.0  initial release
// ============================================================================
interface fir_mac_sequencer_if #(
  parameter int ADDR_W = 7
);
  logic              sample_strobe;
  logic              sample_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] coeff_addr;
  logic              mac_reset;
  logic              mac_wren;
  logic              mac_rden;
  logic              data_zero;
  logic              out_strobe;
  logic              busy;
  logic              overrun;

  modport master (
    input  sample_strobe,
    output sample_we, wr_addr, rd_addr, coeff_addr,
    output mac_reset, mac_wren, mac_rden, data_zero,
    output out_strobe, busy, overrun
  );

  modport slave (
    output sample_strobe,
    input  sample_we, wr_addr, rd_addr, coeff_addr,
    input  mac_reset, mac_wren, mac_rden, data_zero,
    input  out_strobe, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer
// Description : Address/control sequencer for a decimating FIR filter built
//               around one sample ring-buffer RAM, one coefficient ROM and a
//               single MAC. Every DECIM-th sample strobe launches a TAPS-long
//               multiply/accumulate pass over the newest samples.
// Parameters  : TAPS   MAC operations per output (2..2^ADDR_W-DECIM)
//               ADDR_W sample ring and coefficient address width
//               DECIM  input samples per output (>= 1)
// Ports       : clk    system clock
//               reset  synchronous active-high reset
//               bus    fir_mac_sequencer_if.master (sample strobe in;
//                      RAM/ROM addresses, MAC controls, status out)
// Options     : FIR_MAC_SEQUENCER_OVERRUN_EN  when defined, overrun latches
//               on a dropped trigger until reset; otherwise overrun is 0.
// Revision    : 1.0  initial release
// ============================================================================
module fir_mac_sequencer #(
  parameter int TAPS   = 64,
  parameter int ADDR_W = 7,
  parameter int DECIM  = 8
) (
  input  logic                clk,
  input  logic                reset,
  fir_mac_sequencer_if.master bus
);

  // Step counter is one bit wider than the address so it can reach TAPS+1.
  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned TAP_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] c_dcnt_max = CNT_W'(DECIM - 1);
  localparam logic [TAP_W-1:0] c_k_steps  = TAP_W'(TAPS);
  localparam logic [TAP_W-1:0] c_k_flush  = TAP_W'(TAPS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_FLUSH = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] coeff_addr_q, coeff_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [TAP_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              mac_reset_q, mac_reset_d;
  logic              mac_wren_q, mac_wren_d;
  logic              mac_rden_q, mac_rden_d;
  logic              data_zero_q, data_zero_d;
  logic              out_strobe_q, out_strobe_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic w_strobe;
  logic w_trigger;

  assign w_strobe  = bus.sample_strobe;
  assign w_trigger = w_strobe && (dcnt_q == c_dcnt_max);

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    coeff_addr_d = coeff_addr_q;
    base_d       = base_q;
    k_d          = k_q;
    mac_reset_d  = 1'b0;
    mac_wren_d   = 1'b0;
    mac_rden_d   = 1'b0;
    data_zero_d  = 1'b0;
    out_strobe_d = 1'b0;

    // Sample writes and decimation run regardless of the sequencer state.
    wr_addr_d = w_strobe ? (wr_addr_q + ADDR_W'(1)) : wr_addr_q;
    if (w_strobe) begin
      dcnt_d = (dcnt_q == c_dcnt_max) ? '0 : (dcnt_q + CNT_W'(1));
    end else begin
      dcnt_d = dcnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (w_trigger) begin
          // The trigger sample itself is tap 0: base is its write address.
          state_d      = S_CLEAR;
          base_d       = wr_addr_q;
          rd_addr_d    = wr_addr_q;
          coeff_addr_d = '0;
          k_d          = TAP_W'(1);
          mac_reset_d  = 1'b1;
        end
      end
      S_CLEAR, S_ACCUM: begin
        // mac_wren trails the addresses by one cycle (RAM read latency), so
        // it stays on for one cycle after the last address is issued.
        mac_wren_d = 1'b1;
        if (k_q == c_k_flush) begin
          state_d     = S_FLUSH;
          data_zero_d = 1'b1;
        end else begin
          state_d = S_ACCUM;
          if (k_q < c_k_steps) begin
            rd_addr_d    = base_q - k_q[ADDR_W-1:0];
            coeff_addr_d = k_q[ADDR_W-1:0];
          end
          k_d = k_q + TAP_W'(1);
        end
      end
      S_FLUSH: begin
        state_d    = S_READ;
        mac_rden_d = 1'b1;
      end
      S_READ: begin
        state_d      = S_DONE;
        out_strobe_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
    // Any trigger seen outside IDLE (DONE included) is dropped.
    overrun_d = overrun_q || (w_trigger && (state_q != S_IDLE));
`else
    overrun_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      coeff_addr_q <= '0;
      base_q       <= '0;
      k_q          <= '0;
      dcnt_q       <= '0;
      mac_reset_q  <= 1'b1;
      mac_wren_q   <= 1'b0;
      mac_rden_q   <= 1'b0;
      data_zero_q  <= 1'b0;
      out_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      coeff_addr_q <= coeff_addr_d;
      base_q       <= base_d;
      k_q          <= k_d;
      dcnt_q       <= dcnt_d;
      mac_reset_q  <= mac_reset_d;
      mac_wren_q   <= mac_wren_d;
      mac_rden_q   <= mac_rden_d;
      data_zero_q  <= data_zero_d;
      out_strobe_q <= out_strobe_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Reset takes priority over a coincident sample strobe, so the RAM write
  // is suppressed too.
  assign bus.sample_we  = w_strobe && !reset;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.coeff_addr = coeff_addr_q;
  assign bus.mac_reset  = mac_reset_q;
  assign bus.mac_wren   = mac_wren_q;
  assign bus.mac_rden   = mac_rden_q;
  assign bus.data_zero  = data_zero_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Self-checking bench for fir_mac_sequencer (TAPS=8, ADDR_W=4,
//               DECIM=2). A sample RAM / coefficient ROM / MAC harness turns
//               the control outputs into filter results; a timing-rule model
//               predicts every output each cycle and the convolution value.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fir_mac_sequencer;
  localparam int TAPS   = 8;
  localparam int ADDR_W = 4;
  localparam int DECIM  = 2;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_data = 8'd0;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  fir_mac_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .DECIM(DECIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- datapath harness: RAM, ROM (coeff = addr+1), MAC --------
  int dram [DEPTH];
  int ram_q = 0, cof_q = 0, prod = 0, acc = 0, dp_out = 0;

  always @(posedge clk) begin
    if (bus.sample_we) dram[bus.wr_addr] <= int'(sample_data);
    ram_q <= dram[bus.rd_addr];
    cof_q <= int'(bus.coeff_addr) + 1;
    if (bus.mac_reset) begin
      prod <= 0;
      acc  <= 0;
    end else if (bus.mac_wren) begin
      prod <= bus.data_zero ? 0 : ram_q * cof_q;
      acc  <= acc + prod;
    end
    if (bus.mac_rden) dp_out <= acc;
  end

  // ---------------- reference model and per-cycle monitor -------------------
  int  ref_mem [DEPTH];
  int  exp_q [$];
  int  cyc = 0, t_act = 0, base = 0, wr_ptr = 0, dcnt = 0;
  bit  act = 1'b0, ov = 1'b0, prev_rst = 1'b0, mon_en = 1'b0;

  always @(negedge clk) begin : monitor
    int         d;
    int         sum;
    int         e_out;
    logic       e_busy, e_mrst, e_wren, e_dz, e_rden, e_ostb, e_ov, chk_a;
    logic [11:0] ev, av;
    logic [7:0]  ea, aa;

    d = act ? (cyc - t_act) : -100;
    if (prev_rst) begin
      {e_busy, e_mrst, e_wren, e_dz, e_rden, e_ostb} = 6'b010000;
      chk_a = 1'b1;
      ea    = 8'h00;
    end else begin
      e_busy = (d >= 1) && (d <= TAPS + 4);
      e_mrst = (d == 1);
      e_wren = (d >= 2) && (d <= TAPS + 2);
      e_dz   = (d == TAPS + 2);
      e_rden = (d == TAPS + 3);
      e_ostb = (d == TAPS + 4);
      chk_a  = (d >= 1) && (d <= TAPS);
      ea     = {4'(base - (d - 1)), 4'(d - 1)};
    end
`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
    e_ov = ov;
`else
    e_ov = 1'b0;
`endif
    ev = {e_busy, e_mrst, e_wren, e_dz, e_rden, e_ostb, e_ov,
          (bus.sample_strobe && !reset), 4'(wr_ptr)};
    av = {bus.busy, bus.mac_reset, bus.mac_wren, bus.data_zero, bus.mac_rden,
          bus.out_strobe, bus.overrun, bus.sample_we, bus.wr_addr};
    aa = {bus.rd_addr, bus.coeff_addr};

    if (mon_en) begin
      vec_cnt++;
      if (av !== ev) begin
        err_cnt++;
        $display("FAIL ctl cyc=%0d got=%03h expected=%03h", cyc, av, ev);
      end
      if (chk_a) begin
        vec_cnt++;
        if (aa !== ea) begin
          err_cnt++;
          $display("FAIL addr cyc=%0d got rd/cf=%02h expected=%02h", cyc, aa, ea);
        end
      end
      if (e_ostb) begin
        vec_cnt++;
        e_out = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (dp_out != e_out) begin
          err_cnt++;
          $display("FAIL result cyc=%0d got=%0d expected=%0d", cyc, dp_out, e_out);
        end
      end
    end

    // advance the model with this cycle's inputs
    if (reset) begin
      act = 1'b0; wr_ptr = 0; dcnt = 0; ov = 1'b0; prev_rst = 1'b1;
      exp_q.delete();
    end else begin
      prev_rst = 1'b0;
      if (bus.sample_strobe) begin
        ref_mem[wr_ptr] = int'(sample_data);
        if (dcnt == DECIM - 1) begin
          dcnt = 0;
          if (!act || (cyc - t_act) > TAPS + 4) begin
            act = 1'b1; t_act = cyc; base = wr_ptr; sum = 0;
            for (int k = 0; k < TAPS; k++)
              sum += ref_mem[(base - k) & (DEPTH - 1)] * (k + 1);
            exp_q.push_back(sum);
          end else begin
            ov = 1'b1;
          end
        end else begin
          dcnt++;
        end
        wr_ptr = (wr_ptr + 1) % DEPTH;
      end
    end
    cyc++;
  end

  // ---------------- directed helpers ----------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [7:0] dat);
    bus.sample_strobe = 1'b1;
    sample_data       = dat;
    tick();
    bus.sample_strobe = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int expv);
    vec_cnt++;
    if (got != expv) begin
      err_cnt++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // bounded wait for out_strobe; returns offset from the current cycle
  task automatic wait_out(output int n, output int val);
    n = 0;
    while (!bus.out_strobe && n < 30) begin
      tick();
      n++;
    end
    val = dp_out;
  endtask

  typedef struct {
    logic [5:0] ctl;   // busy, mac_reset, mac_wren, data_zero, mac_rden, out_strobe
    logic       chk_a;
    logic [3:0] rd;
    logic [3:0] cf;
  } row_t;

  row_t tbl [13];
  int   n, val, cnt, exp_ov;

  initial begin
    // one computation with base = 3, rows are cycles T+1 .. T+13
    tbl[0]  = '{6'b110000, 1'b1, 4'd3,  4'd0};
    tbl[1]  = '{6'b101000, 1'b1, 4'd2,  4'd1};
    tbl[2]  = '{6'b101000, 1'b1, 4'd1,  4'd2};
    tbl[3]  = '{6'b101000, 1'b1, 4'd0,  4'd3};
    tbl[4]  = '{6'b101000, 1'b1, 4'd15, 4'd4};
    tbl[5]  = '{6'b101000, 1'b1, 4'd14, 4'd5};
    tbl[6]  = '{6'b101000, 1'b1, 4'd13, 4'd6};
    tbl[7]  = '{6'b101000, 1'b1, 4'd12, 4'd7};
    tbl[8]  = '{6'b101000, 1'b0, 4'd0,  4'd0};
    tbl[9]  = '{6'b101100, 1'b0, 4'd0,  4'd0};
    tbl[10] = '{6'b100010, 1'b0, 4'd0,  4'd0};
    tbl[11] = '{6'b100001, 1'b0, 4'd0,  4'd0};
    tbl[12] = '{6'b000000, 1'b0, 4'd0,  4'd0};
`ifdef FIR_MAC_SEQUENCER_OVERRUN_EN
    exp_ov = 1;
`else
    exp_ov = 0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      dram[i]    = 0;
      ref_mem[i] = 0;
    end
    bus.sample_strobe = 1'b0;

    // reset state
    idle(3);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_mac_reset", int'(bus.mac_reset), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_overrun", int'(bus.overrun), 0);

    // base = 3 with an impulse of 1 as the trigger sample
    idle(2);
    strobe(8'd0); idle(20);
    strobe(8'd0); idle(20);
    strobe(8'd0); idle(20);
    strobe(8'd1);
    for (int r = 0; r < 13; r++) begin
      chk($sformatf("tbl_ctl[%0d]", r),
          int'({bus.busy, bus.mac_reset, bus.mac_wren, bus.data_zero,
                bus.mac_rden, bus.out_strobe}), int'(tbl[r].ctl));
      if (tbl[r].chk_a)
        chk($sformatf("tbl_addr[%0d]", r), int'({bus.rd_addr, bus.coeff_addr}),
            int'({tbl[r].rd, tbl[r].cf}));
      if (r == 11) chk("impulse_out0", dp_out, 1);
      tick();
    end

    // following outputs walk the coefficients in tap order (every DECIM-th)
    for (int j = 1; j < 4; j++) begin
      idle(8);
      strobe(8'd0); idle(19);
      strobe(8'd0);
      wait_out(n, val);
      chk($sformatf("impulse_out%0d", j), val, 2 * j + 1);
    end

    // trigger five cycles into busy is dropped
    idle(20);
    strobe(8'd7); idle(20);
    strobe(8'd9);          // trigger, now at T+1
    strobe(8'd2);          // T+1, non-trigger
    idle(3);
    strobe(8'd4);          // T+5, trigger while busy
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_strobe) cnt++;
      tick();
    end
    chk("drop_out_count", cnt, 1);
    chk("drop_overrun", int'(bus.overrun), exp_ov);
    chk("drop_busy_after", int'(bus.busy), 0);

    // reset in ACCUM k=4 aborts the pass
    reset = 1'b1; idle(2); reset = 1'b0;
    chk("rst2_overrun", int'(bus.overrun), 0);
    strobe(8'd3); idle(20);
    strobe(8'd6);          // base = 1, now at T+1
    idle(4);               // T+5
    chk("abort_rd_k4", int'(bus.rd_addr), 13);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_strobe) cnt++;
      tick();
    end
    chk("abort_no_out", cnt, 0);
    chk("abort_wr_addr", int'(bus.wr_addr), 0);
    chk("abort_overrun", int'(bus.overrun), 0);
    strobe(8'd1); idle(3);
    chk("abort_first_strobe_idle", int'(bus.busy), 0);
    strobe(8'd1);
    chk("abort_second_strobe_busy", int'(bus.busy), 1);
    idle(20);

    // strobes every 20 cycles across the wr_addr wrap: output 12 cycles later
    for (int i = 0; i < 20; i++) begin
      strobe(8'($urandom_range(0, 255)));
      if (i % 2 == 1) begin
        n = 1;
        while (!bus.out_strobe && n < 30) begin
          tick();
          n++;
        end
        chk($sformatf("latency[%0d]", i), n, TAPS + 4);
        idle(20 - n);
      end else begin
        idle(19);
      end
    end

    // random strobe spacing, data and occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        idle($urandom_range(1, 3));
        reset = 1'b0;
      end
      strobe(8'($urandom_range(0, 255)));
      idle($urandom_range(1, 24));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
